pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined two's-complement add/subtract unit; successor to the team's fixed 16-bit ripple-carry adder.
- Operand width and pipeline depth are configurable; the block adds subtract mode, carry/overflow/zero flags and a valid/ready handshake.
- Sits between the operand register file and the result writeback path of the FPGA datapath.

Parameters:
WIDTH, 16, operand and result width in bits; must be >= 2.
STAGES, 2, number of pipeline segments; WIDTH must be divisible by STAGES; 1 = single registered stage.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in; ignored when in_sub=1
in_sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  result bits
out_cout  output  1  carry out of MSB (in subtract mode: 1 = no borrow)
out_ovf  output  1  signed overflow
out_zero  output  1  out_sum == 0

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rst_n).
- Reset: all stage valid bits clear and all stage data registers clear. While rst_n=0: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0. in_ready=1 from the first cycle after reset deasserts.
- Reset asserted mid-operation discards every in-flight beat; nothing is replayed.
- Segmentation: SEG = WIDTH/STAGES. Stage k adds bits [k*SEG +: SEG] using the carry registered by stage k-1; stage 0 uses the effective carry-in (in_sub ? 1 : in_cin).
- Each stage registers:
  - its partial sum;
  - its carry-out;
  - the not-yet-added upper operand bits, with B already inverted when subtracting;
  - the carry into its MSB. This is needed only by the last stage, for overflow.
- Latency: exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid, provided there is no backpressure.
- Throughput: one beat per cycle.
- Handshake:
  - Each stage holds a valid bit and advances when the next stage is empty or advancing.
  - The last stage advances on out_ready.
  - in_ready = !stage0_valid || stage0_advancing. This is a combinational ready chain; no skid buffer.
  - out_* remain stable while out_valid && !out_ready.
  - in_valid may drop without being accepted; inputs are sampled only on acceptance.
- Flags, all registered with the final stage:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - out_zero = ~|out_sum. It reflects the final out_sum, including after saturation.
- Wrap-around: without saturation the sum is modulo 2^WIDTH; the flags report the wrap.
- Simultaneous accept and emit in the same cycle with a full pipeline: must sustain 100% throughput with no bubble.

Optional Feature:
- Macro: PIPELINED_ADDER_SATURATE_EN.
- When defined:
  - Adds input port in_sat (1 bit), carried along the pipeline with its beat.
  - If in_sat=1 and out_ovf=1, out_sum clamps to the signed limit: 0x7FFF for positive overflow, 0x8000 for negative overflow (shown for WIDTH=16).
  - Overflow direction = sign of operand A.
  - out_ovf still reports 1 when a clamp occurs.
- When undefined: the port is absent and the result always wraps.

Decomposition:
- Package adder_pkg:
  - localparam OP_ADD=1'b0, OP_SUB=1'b1;
  - typedef for the flag bundle {cout, ovf, zero};
  - function to compute SEG with an elaboration check that WIDTH % STAGES == 0.
- Sub-module adder_segment (combinational):
  - parameter SEG; inputs a, b, cin; outputs sum, cout, c_msb (carry into the MSB).
  - Instantiated once per stage via a generate loop.
- The top level holds all registers and the handshake logic.

Test Plan (WIDTH=16, STAGES=2):
- Add: A=0x1234, B=0x0FF1, cin=1, sub=0 -> after 2 cycles sum=0x2226, cout=0, ovf=0, zero=0.
- Carry across the segment boundary and wrap: A=0xFFFF, B=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0, zero=1.
- Signed overflow with subtract: A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1. With PIPELINED_ADDER_SATURATE_EN and in_sat=1 -> sum=0x8000, ovf=1.
- Backpressure: stream 5 beats (A=i, B=i) with out_ready low for cycles 3-6.
  - Required: out_sum holds stable, in_ready drops once both stages are full, results 0,2,4,6,8 arrive in order with none lost or duplicated.
- Full throughput: 20 back-to-back random beats with out_ready=1 -> one result per cycle after 2 cycles latency, matching a reference model including flags.
- Reset mid-flight: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately (asynchronous), all outputs 0; after release, no stale beat emerges.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: opcode encodings,
// the registered flag bundle and the per-stage segment width helper.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    // Returns 0 for an illegal split so the top level can reject it at elaboration.
    function automatic int seg_width(input int width, input int stages);
        if (stages < 1 || width < 2 || (width % stages) != 0)
            return 0;
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// One SEG-bit slice of the adder: sum, carry out and the carry into the slice MSB
// (the latter feeds signed-overflow detection in the final slice).
module adder_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    assign sum   = full[SEG-1:0];
    assign cout  = full[SEG];
    // Recover the carry into the MSB from the MSB's own sum equation.
    assign c_msb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement add/subtract with per-stage valid/ready flow control.
// Define PIPELINED_ADDER_SATURATE_EN to add in_sat and clamp overflowing results.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
`ifdef PIPELINED_ADDER_SATURATE_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (SEG == 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_adv;

    assign b_eff   = (in_sub == OP_SUB) ? ~in_b : in_b;
    assign cin_eff = (in_sub == OP_SUB) ? 1'b1 : in_cin;

    // Ready ripples backwards from the output: a stage moves when its successor
    // is empty or moving on the same edge.
    always_comb begin
        stage_adv = '0;
        stage_adv[STAGES-1] = stage_valid[STAGES-1] && out_ready;
        for (int k = STAGES - 2; k >= 0; k--)
            stage_adv[k] = stage_valid[k] && (!stage_valid[k+1] || stage_adv[k+1]);
    end

    assign in_ready = !stage_valid[0] || stage_adv[0];

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int HI = (gi + 1) * SEG;
        localparam int UP = WIDTH - HI;

        logic [SEG-1:0] seg_a;
        logic [SEG-1:0] seg_b;
        logic [SEG-1:0] seg_sum;
        logic           seg_cin;
        logic           seg_cout;
        logic           seg_cmsb;
        logic [HI-1:0]  next_sum;
        logic [HI-1:0]  load_sum;
        logic [HI-1:0]  sum_reg;
        logic           take;
        logic           valid_reg;
`ifdef PIPELINED_ADDER_SATURATE_EN
        logic           sat_in;
`endif

        adder_segment #(.SEG(SEG)) u_seg (
            .a     (seg_a),
            .b     (seg_b),
            .cin   (seg_cin),
            .sum   (seg_sum),
            .cout  (seg_cout),
            .c_msb (seg_cmsb)
        );

        if (gi == 0) begin : g_src
            assign take     = in_valid && in_ready;
            assign seg_a    = in_a[SEG-1:0];
            assign seg_b    = b_eff[SEG-1:0];
            assign seg_cin  = cin_eff;
            assign next_sum = seg_sum;
`ifdef PIPELINED_ADDER_SATURATE_EN
            assign sat_in   = in_sat;
`endif
        end else begin : g_src
            assign take     = stage_adv[gi-1];
            assign seg_a    = g_stage[gi-1].g_ops.a_reg[SEG-1:0];
            assign seg_b    = g_stage[gi-1].g_ops.b_reg[SEG-1:0];
            assign seg_cin  = g_stage[gi-1].g_mid.carry_reg;
            assign next_sum = {seg_sum, g_stage[gi-1].sum_reg};
`ifdef PIPELINED_ADDER_SATURATE_EN
            assign sat_in   = g_stage[gi-1].g_mid.sat_reg;
`endif
        end

        // Operand bits above this slice ride along until their own stage adds them.
        if (UP > 0) begin : g_ops
            logic [UP-1:0] a_next;
            logic [UP-1:0] b_next;
            logic [UP-1:0] a_reg;
            logic [UP-1:0] b_reg;

            if (gi == 0) begin : g_from
                assign a_next = in_a[WIDTH-1:HI];
                assign b_next = b_eff[WIDTH-1:HI];
            end else begin : g_from
                assign a_next = g_stage[gi-1].g_ops.a_reg[UP+SEG-1:SEG];
                assign b_next = g_stage[gi-1].g_ops.b_reg[UP+SEG-1:SEG];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (take) begin
                    a_reg <= a_next;
                    b_reg <= b_next;
                end
            end
        end

        if (gi == STAGES - 1) begin : g_last
            flags_t flags_reg;
            logic   ovf;

            assign ovf = seg_cmsb ^ seg_cout;

            always_comb begin
                load_sum = next_sum;
`ifdef PIPELINED_ADDER_SATURATE_EN
                // On overflow the wrapped MSB is the inverse of A's sign.
                if (sat_in && ovf)
                    load_sum = next_sum[HI-1] ? {1'b0, {(HI-1){1'b1}}}
                                              : {1'b1, {(HI-1){1'b0}}};
`endif
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    flags_reg <= '0;
                end else if (take) begin
                    flags_reg.cout <= seg_cout;
                    flags_reg.ovf  <= ovf;
                    flags_reg.zero <= ~|load_sum;
                end
            end
        end else begin : g_mid
            logic carry_reg;
            logic cmsb_unused;
`ifdef PIPELINED_ADDER_SATURATE_EN
            logic sat_reg;
`endif

            assign load_sum    = next_sum;
            assign cmsb_unused = seg_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    carry_reg <= 1'b0;
`ifdef PIPELINED_ADDER_SATURATE_EN
                    sat_reg   <= 1'b0;
`endif
                end else if (take) begin
                    carry_reg <= seg_cout;
`ifdef PIPELINED_ADDER_SATURATE_EN
                    sat_reg   <= sat_in;
`endif
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                sum_reg   <= '0;
            end else if (take) begin
                valid_reg <= 1'b1;
                sum_reg   <= load_sum;
            end else if (stage_adv[gi]) begin
                valid_reg <= 1'b0;
            end
        end

        assign stage_valid[gi] = valid_reg;
    end

    assign out_valid = stage_valid[STAGES-1];
    assign out_sum   = g_stage[STAGES-1].sum_reg;
    assign out_cout  = g_stage[STAGES-1].g_last.flags_reg.cout;
    assign out_ovf   = g_stage[STAGES-1].g_last.flags_reg.ovf;
    assign out_zero  = g_stage[STAGES-1].g_last.flags_reg.zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=2); honours
// PIPELINED_ADDER_SATURATE_EN when defined.
module tb_pipelined_adder;

    localparam int W      = 16;
    localparam int STAGES = 2;
`ifdef PIPELINED_ADDER_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         in_sat = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;
    logic [W-1:0] out_sum;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] seen_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           pops = 0;
    int           blocked = 0;
    bit           lat_check = 1'b0;
    bit           collect = 1'b0;

    pipelined_adder #(.WIDTH(W), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
`ifdef PIPELINED_ADDER_SATURATE_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference computed from integer arithmetic: true signed result range and unsigned carry/borrow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic sat);
        exp_t r;
        int   sa, sb, t, u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            t = sa - sb;
            u = int'(a) - int'(b);
            r.cout = (a >= b);
        end else begin
            t = sa + sb + int'(cin);
            u = int'(a) + int'(b) + int'(cin);
            r.cout = (u > 65535);
        end
        r.sum = u[W-1:0];
        r.ovf = (t > 32767) || (t < -32768);
        if (SAT_EN && sat && r.ovf)
            r.sum = (t > 0) ? 16'h7FFF : 16'h8000;
        r.zero = (r.sum == '0);
        r.acc = 0;
        return r;
    endfunction

    // Single compare process: every valid output is checked against the model queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_sum), 32'hDEAD);
                end else begin
                    chk("sum",  32'(out_sum),  32'(exp_q[0].sum));
                    chk("cout", 32'(out_cout), 32'(exp_q[0].cout));
                    chk("ovf",  32'(out_ovf),  32'(exp_q[0].ovf));
                    chk("zero", 32'(out_zero), 32'(exp_q[0].zero));
                    if (out_ready) begin
                        if (lat_check)
                            chk("latency", 32'(cyc - exp_q[0].acc), 32'(STAGES));
                        if (collect)
                            seen_q.push_back(out_sum);
                        $display("beat %0d: sum=%h cout=%b ovf=%b zero=%b",
                                 pops, out_sum, out_cout, out_ovf, out_zero);
                        pops++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && !in_ready)
                blocked++;
            if (in_valid && in_ready) begin
                e = model(in_a, in_b, in_cin, in_sub, in_sat);
                e.acc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic sat, output int waited);
        waited = 0;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_sat = sat;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 32'(waited), 32'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic sat,
                            input logic [W-1:0] es, input logic ec, input logic eo, input logic ez);
        int w;
        int n;
        send(a, b, cin, sub, sat, w);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_lat"},   32'(n + 1),     32'(STAGES));
        chk({name, "_sum"},   32'(out_sum),   32'(es));
        chk({name, "_cout"},  32'(out_cout),  32'(ec));
        chk({name, "_ovf"},   32'(out_ovf),   32'(eo));
        chk({name, "_zero"},  32'(out_zero),  32'(ez));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   w;
        int   tot;
        int   stale;
        int   pops0;
        exp_t m;

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_cout",  32'(out_cout),  32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        chk("rst_out_zero",  32'(out_zero),  32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Literal pins on the model itself: {cout, ovf, zero, sum}.
        m = model(16'h1234, 16'h0FF1, 1'b1, 1'b0, 1'b0);
        chk("model_add",  32'({m.cout, m.ovf, m.zero, m.sum}), 32'h0_2226);
        m = model(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("model_wrap", 32'({m.cout, m.ovf, m.zero, m.sum}), 32'h5_0000);
        m = model(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        chk("model_sub",  32'({m.cout, m.ovf, m.zero, m.sum}), 32'h6_7FFF);
        m = model(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        chk("model_sat",  32'({m.cout, m.ovf, m.zero, m.sum}), SAT_EN ? 32'h6_8000 : 32'h6_7FFF);

        @(posedge clk);
        #1;
        lat_check = 1'b1;
        directed("add",     16'h1234, 16'h0FF1, 1'b1, 1'b0, 1'b0, 16'h2226, 1'b0, 1'b0, 1'b0);
        directed("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed("sub_sat", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1,
                 SAT_EN ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0);
        directed("add_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1,
                 SAT_EN ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_cin", 16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure: out_ready low for four cycles in the middle of a 5-beat stream.
        lat_check = 1'b0;
        collect = 1'b1;
        seen_q.delete();
        blocked = 0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(16'(i), 16'(i), 1'b0, 1'b0, 1'b0, w);
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    @(posedge clk);
                    #1;
                    out_ready = !(k >= 3 && k <= 6);
                end
            end
        join
        drain();
        collect = 1'b0;
        chk("bp_count", 32'(seen_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < seen_q.size(); i++)
            chk("bp_order", 32'(seen_q[i]), 32'(2 * i));
        chk("bp_in_ready_dropped", 32'(blocked > 0), 32'd1);

        // Full throughput: 20 back-to-back beats, no backpressure.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        lat_check = 1'b1;
        tot = 0;
        pops0 = pops;
        for (int i = 0; i < 20; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), w);
            tot += w;
        end
        drain();
        chk("tp_no_bubble", 32'(tot), 32'd0);
        chk("tp_results", 32'(pops - pops0), 32'd20);

        // Reset with two beats in flight.
        @(posedge clk);
        #1;
        send(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0, w);
        send(16'h0303, 16'h0404, 1'b0, 1'b0, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_sum",   32'(out_sum),   32'd0);
        chk("mid_rst_out_cout",  32'(out_cout),  32'd0);
        chk("mid_rst_out_ovf",   32'(out_ovf),   32'd0);
        chk("mid_rst_out_zero",  32'(out_zero),  32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid)
                stale++;
        end
        chk("mid_rst_stale", 32'(stale), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
